z80_idx_store_sequencer: RTL and testbench
==========================================

// Module: z80_idx_store_sequencer
// PURPOSE
// Multi-cycle sequencer for LD (IX/IY+d),n (DD/FD 36 d n) in the Z80 core.
// Fetches the four instruction bytes over a shared byte bus with a req/ack handshake.
// Forms the effective address IX/IY + sign-extended d, then issues the memory write.
// Publishes a one-cycle retirement record for the z80fi checker.
// PARAMETERS
// CALC_CYCLES  2  internal address-add cycles between fetching n and the write (>=1)
// PORTS
// clk            in   1   clock; all state changes on the rising edge
// reset          in   1   asynchronous, active-high reset
// start          in   1   begin sequence at start_pc; ignored unless idle
// start_pc       in   16  address of the prefix byte
// reg_ix         in   16  current IX
// reg_iy         in   16  current IY
// busy           out  1   high from the cycle after an accepted start through the done cycle
// bus_req        out  1   bus transfer request
// bus_we         out  1   1=write, 0=read; valid while bus_req
// bus_addr       out  16  transfer address; valid while bus_req
// bus_wdata      out  8   write data; valid while bus_req && bus_we
// bus_ack        in   1   transfer completes in any cycle with bus_req && bus_ack
// bus_rdata      in   8   read data; sampled on the ack cycle
// done           out  1   one-cycle pulse: instruction retired
// illegal        out  1   one-cycle pulse: bad prefix/opcode, nothing written
// retire_insn    out  32  {n,d,36,prefix}; byte0 = prefix in bits 7:0
// retire_waddr   out  16  effective write address
// retire_wdata   out  8   byte written (n)
// retire_pc_next out  16  start_pc + 4
// BEHAVIOUR
// - Reset (async, any state): state IDLE; every output 0; latched bytes/addresses 0.
//   Any transfer in flight is abandoned and no write is issued.
// - States: IDLE, F_PFX, F_OP, F_D, F_N, CALC, WRITE, DONE.
// - IDLE: start=1 latches start_pc; next state F_PFX. start is ignored in every other state.
// - F_PFX/F_OP/F_D/F_N: bus_req=1, bus_we=0, bus_addr = pc+0/+1/+2/+3 (mod 2^16).
//   Each holds req/addr stable until ack, then advances one state. Wait states are unbounded.
// - F_PFX ack: rdata DD selects IX, FD selects IY. The selected register is sampled this cycle.
//   Any other byte: illegal=1 next cycle, then IDLE.
// - F_OP ack: rdata != 36 -> illegal=1 next cycle, then IDLE.
// - CALC: bus_req=0 for exactly CALC_CYCLES cycles.
//   waddr = idx + {{8{d[7]}},d} mod 2^16 (FFFF + 1 wraps to 0000).
// - WRITE: bus_req=1, bus_we=1, bus_addr=waddr, bus_wdata=n; held until ack.
// - DONE: done=1 for one cycle; retire_* valid only while done=1, 0 otherwise; next IDLE.
// - illegal cycle: retire_* = 0, no WRITE ever issued.
// - bus_req is 0 in IDLE, CALC, DONE and the illegal cycle. Each request lasts >=1 cycle.
//   A new request starts the cycle after the previous ack.
// - Latency with ack tied high: start@0, reads @1-4, CALC @5..4+C, write @5+C, done @6+C.
//   With C=2, done is at cycle 8.
// - busy=1 in all non-IDLE states, including the illegal-pulse cycle.
// - reg_ix/reg_iy changes after the prefix ack do not affect waddr.
// TESTING
// - DD 36 05 AA @pc=1000, IX=2000, ack=1 -> reads 1000..1003, write [2005]=AA.
//   done@cycle 8, retire_pc_next=1004, retire_insn=AA0536DD.
// - FD 36 FE 55, IY=0001 -> write [FFFF]=55; d=80, IY=0000 -> write [FF80].
// - pc=FFFE -> fetch addrs FFFE,FFFF,0000,0001; retire_pc_next=0002.
// - ack withheld 3 cycles on F_D and on WRITE -> req/addr/wdata stable; one write; done delayed 6 cycles.
// - prefix DD, opcode 34 -> illegal pulse, no write request, no done, IDLE; start while busy ignored.
// - reset asserted mid-WRITE (before ack) -> bus_req drops immediately; all outputs 0; fresh start works.

Source files
------------

// File: rtl/z80_idx_store_sequencer_if.sv
// Shared byte bus between the indexed-store sequencer and memory.
// The sequencer drives request/address/data; the memory side answers with ack/rdata.
interface z80_idx_store_sequencer_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/z80_idx_store_sequencer.sv
// Sequencer for LD (IX/IY+d),n: fetches DD/FD 36 d n, adds the displacement,
// writes n, and publishes a one-cycle retirement record.
//
// state   | meaning
// IDLE    | waiting for start
// F_PFX   | reading prefix byte at pc
// F_OP    | reading opcode byte at pc+1
// F_D     | reading displacement at pc+2
// F_N     | reading immediate at pc+3
// CALC    | forming idx + sext(d), CALC_CYCLES cycles
// WRITE   | writing n to the effective address
// DONE    | retirement pulse
// ILL     | illegal pulse, nothing written
module z80_idx_store_sequencer #(
    parameter int CALC_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [15:0]                        start_pc,
    input  logic [15:0]                        reg_ix,
    input  logic [15:0]                        reg_iy,
    output logic                               busy,
    z80_idx_store_sequencer_if.master          bus,
    output logic                               done,
    output logic                               illegal,
    output logic [31:0]                        retire_insn,
    output logic [15:0]                        retire_waddr,
    output logic [7:0]                         retire_wdata,
    output logic [15:0]                        retire_pc_next
);

    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CALC_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_F_PFX, S_F_OP, S_F_D, S_F_N, S_CALC, S_WRITE, S_DONE, S_ILL
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   pc;
    logic [15:0]   idx;
    logic [15:0]   waddr;
    logic [7:0]    prefix;
    logic [7:0]    disp;
    logic [7:0]    imm;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // The index register is captured on the prefix ack so later IX/IY updates cannot move the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            idx    <= '0;
            waddr  <= '0;
            prefix <= '0;
            disp   <= '0;
            imm    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) pc <= start_pc;
                S_F_PFX: if (bus.bus_ack) begin
                    prefix <= bus.bus_rdata;
                    idx    <= (bus.bus_rdata == 8'hFD) ? reg_iy : reg_ix;
                end
                S_F_D:   if (bus.bus_ack) disp <= bus.bus_rdata;
                S_F_N:   if (bus.bus_ack) begin
                    imm <= bus.bus_rdata;
                    cnt <= CNT_LOAD;
                end
                S_CALC: begin
                    waddr <= idx + {{8{disp[7]}}, disp};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_F_PFX;
            S_F_PFX: if (bus.bus_ack)
                         state_nxt = (bus.bus_rdata == 8'hDD || bus.bus_rdata == 8'hFD) ? S_F_OP : S_ILL;
            S_F_OP:  if (bus.bus_ack)
                         state_nxt = (bus.bus_rdata == 8'h36) ? S_F_D : S_ILL;
            S_F_D:   if (bus.bus_ack) state_nxt = S_F_N;
            S_F_N:   if (bus.bus_ack) state_nxt = S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_WRITE;
            S_WRITE: if (bus.bus_ack) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ILL:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != S_IDLE);
        bus.bus_req    = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = '0;
        bus.bus_wdata  = '0;
        done           = 1'b0;
        illegal        = 1'b0;
        retire_insn    = '0;
        retire_waddr   = '0;
        retire_wdata   = '0;
        retire_pc_next = '0;
        case (state)
            S_F_PFX: begin bus.bus_req = 1'b1; bus.bus_addr = pc;          end
            S_F_OP:  begin bus.bus_req = 1'b1; bus.bus_addr = pc + 16'd1; end
            S_F_D:   begin bus.bus_req = 1'b1; bus.bus_addr = pc + 16'd2; end
            S_F_N:   begin bus.bus_req = 1'b1; bus.bus_addr = pc + 16'd3; end
            S_WRITE: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = waddr;
                bus.bus_wdata = imm;
            end
            S_DONE: begin
                done           = 1'b1;
                retire_insn    = {imm, disp, 8'h36, prefix};
                retire_waddr   = waddr;
                retire_wdata   = imm;
                retire_pc_next = pc + 16'd4;
            end
            S_ILL:   illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z80_idx_store_sequencer.sv
// Randomized bench for the indexed-store sequencer: a transaction-level model
// predicts every bus transfer and retirement record.
module tb_z80_idx_store_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_pc = '0;
    logic [15:0] reg_ix = '0;
    logic [15:0] reg_iy = '0;
    logic        busy, done, illegal;
    logic [31:0] retire_insn;
    logic [15:0] retire_waddr, retire_pc_next;
    logic [7:0]  retire_wdata;

    z80_idx_store_sequencer_if bif ();

    z80_idx_store_sequencer #(.CALC_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_pc       (start_pc),
        .reg_ix         (reg_ix),
        .reg_iy         (reg_iy),
        .busy           (busy),
        .bus            (bif.master),
        .done           (done),
        .illegal        (illegal),
        .retire_insn    (retire_insn),
        .retire_waddr   (retire_waddr),
        .retire_wdata   (retire_wdata),
        .retire_pc_next (retire_pc_next)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign bif.bus_rdata = mem[bif.bus_addr];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } xfer_t;

    xfer_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          wait_tab[5];
    int          xfer_idx = 0;
    int          waited = 0;
    int          done_cnt = 0;
    int          ill_cnt = 0;
    logic        exp_ill = 1'b0;
    logic [31:0] exp_insn = '0;
    logic [15:0] exp_waddr = '0, exp_pcn = '0;
    logic [7:0]  exp_wdata = '0;
    logic [31:0] last_insn = '0;
    logic [15:0] last_waddr = '0, last_pcn = '0;
    logic [7:0]  last_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: transfer k of the current instruction is acked after wait_tab[k] idle cycles.
    initial begin
        logic fire;
        bif.bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            fire = bif.bus_req && bif.bus_ack;
            @(posedge clk);
            #1;
            if (fire) begin
                xfer_idx++;
                waited = 0;
            end
            if (bif.bus_req && xfer_idx < 5) begin
                if (waited >= wait_tab[xfer_idx]) bif.bus_ack = 1'b1;
                else begin
                    bif.bus_ack = 1'b0;
                    waited++;
                end
            end else begin
                bif.bus_ack = 1'b0;
            end
        end
    end

    // Compare process: every completed transfer, request stability, and retirement outputs.
    initial begin
        logic        prev_wait = 1'b0;
        logic        prev_we = 1'b0;
        logic [15:0] prev_addr = '0;
        logic [7:0]  prev_wdata = '0;
        xfer_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait = 1'b0;
            end else begin
                if (bif.bus_req && prev_wait) begin
                    chk("hold_we", bif.bus_we, prev_we);
                    chk("hold_addr", bif.bus_addr, prev_addr);
                    chk("hold_wdata", bif.bus_wdata, prev_wdata);
                end
                if (bif.bus_req && bif.bus_ack) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got addr %0h we %0b expected none", bif.bus_addr, bif.bus_we);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_we", bif.bus_we, e.we);
                        chk("xfer_addr", bif.bus_addr, e.addr);
                        if (e.we) chk("xfer_wdata", bif.bus_wdata, e.wdata);
                    end
                end
                prev_wait  = bif.bus_req && !bif.bus_ack;
                prev_we    = bif.bus_we;
                prev_addr  = bif.bus_addr;
                prev_wdata = bif.bus_wdata;
                if (done) begin
                    done_cnt++;
                    chk("done_expected", exp_ill, 1'b0);
                    chk("retire_insn", retire_insn, exp_insn);
                    chk("retire_waddr", retire_waddr, exp_waddr);
                    chk("retire_wdata", retire_wdata, exp_wdata);
                    chk("retire_pc_next", retire_pc_next, exp_pcn);
                    last_insn  = retire_insn;
                    last_waddr = retire_waddr;
                    last_wdata = retire_wdata;
                    last_pcn   = retire_pc_next;
                end else begin
                    chk("retire_zero", {retire_insn, retire_waddr, retire_wdata, retire_pc_next}, 64'd0);
                end
                if (illegal) begin
                    ill_cnt++;
                    chk("illegal_expected", exp_ill, 1'b1);
                end
            end
        end
    end

    // Loads the instruction into memory, builds the expected transfer list, runs it to completion.
    task automatic run_insn(input logic [15:0] pc, input logic [7:0] pfx, input logic [7:0] op,
                            input logic [7:0] d, input logic [7:0] n, input logic [15:0] ix,
                            input logic [15:0] iy, input bit poke, output int lat);
        logic legal_pfx, legal;
        logic [15:0] ea;
        int cyc, d0, i0;
        @(negedge clk);
        legal_pfx = (pfx == 8'hDD) || (pfx == 8'hFD);
        legal     = legal_pfx && (op == 8'h36);
        ea        = ((pfx == 8'hFD) ? iy : ix) + {{8{d[7]}}, d};
        mem[pc]          = pfx;
        mem[pc + 16'd1]  = op;
        mem[pc + 16'd2]  = d;
        mem[pc + 16'd3]  = n;
        exp_q.delete();
        exp_q.push_back('{1'b0, pc, 8'h00});
        if (legal_pfx) exp_q.push_back('{1'b0, pc + 16'd1, 8'h00});
        if (legal) begin
            exp_q.push_back('{1'b0, pc + 16'd2, 8'h00});
            exp_q.push_back('{1'b0, pc + 16'd3, 8'h00});
            exp_q.push_back('{1'b1, ea, n});
        end
        exp_ill   = !legal;
        exp_insn  = {n, d, op, pfx};
        exp_waddr = ea;
        exp_wdata = n;
        exp_pcn   = pc + 16'd4;
        d0 = done_cnt;
        i0 = ill_cnt;
        xfer_idx = 0;
        waited = 0;
        @(posedge clk); #1;
        start = 1'b1; start_pc = pc; reg_ix = ix; reg_iy = iy;
        @(posedge clk); #1;
        start = 1'b0; start_pc = 16'($urandom);
        cyc = 1;
        chk("busy_after_start", busy, 1'b1);
        while (!(done || illegal) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start = poke && (cyc == 2);
            chk("busy_in_flight", busy, 1'b1);
            if (xfer_idx >= 1) begin
                reg_ix = 16'($urandom);
                reg_iy = 16'($urandom);
            end
        end
        start = 1'b0;
        chk("latency_bound", cyc < 300, 1'b1);
        lat = cyc;
        @(posedge clk); #1;
        chk("busy_idle_after", busy, 1'b0);
        chk("bus_req_idle_after", bif.bus_req, 1'b0);
        chk("done_count", done_cnt - d0, legal ? 1 : 0);
        chk("illegal_count", ill_cnt - i0, legal ? 0 : 1);
        chk("xfers_left", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        wait_tab = '{0, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", bif.bus_req, 1'b0);
        chk("rst_outs", {done, illegal, retire_insn, retire_pc_next}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_insn(16'h1000, 8'hDD, 8'h36, 8'h05, 8'hAA, 16'h2000, 16'h7777, 1'b0, lat);
        chk("lat_basic", lat, 8);
        chk("pin_insn", last_insn, 32'hAA0536DD);
        chk("pin_waddr", last_waddr, 16'h2005);
        chk("pin_wdata", last_wdata, 8'hAA);
        chk("pin_pcn", last_pcn, 16'h1004);

        run_insn(16'h0200, 8'hFD, 8'h36, 8'hFE, 8'h55, 16'h1234, 16'h0001, 1'b0, lat);
        chk("pin_iy_wrap_down", last_waddr, 16'hFFFF);
        run_insn(16'h0300, 8'hFD, 8'h36, 8'h80, 8'h11, 16'h1234, 16'h0000, 1'b0, lat);
        chk("pin_iy_neg128", last_waddr, 16'hFF80);
        run_insn(16'hFFFE, 8'hDD, 8'h36, 8'h01, 8'h22, 16'hFFFF, 16'h0000, 1'b0, lat);
        chk("pin_pc_wrap", last_pcn, 16'h0002);
        chk("pin_ix_wrap_up", last_waddr, 16'h0000);

        wait_tab = '{0, 0, 3, 0, 3};
        run_insn(16'h4000, 8'hDD, 8'h36, 8'h10, 8'h77, 16'h0100, 16'h0000, 1'b0, lat);
        chk("lat_waits", lat, 14);
        chk("pin_wait_waddr", last_waddr, 16'h0110);

        wait_tab = '{0, 0, 0, 0, 0};
        run_insn(16'h5000, 8'hDD, 8'h34, 8'h10, 8'h77, 16'h0100, 16'h0000, 1'b1, lat);
        chk("lat_illegal_op", lat, 3);
        repeat (4) begin
            @(posedge clk); #1;
            chk("quiet_after_illegal", {busy, bif.bus_req}, 2'b00);
        end
        run_insn(16'h5100, 8'hED, 8'h36, 8'h10, 8'h77, 16'h0100, 16'h0000, 1'b0, lat);
        chk("lat_illegal_pfx", lat, 2);

        // Reset while the write is pending.
        wait_tab = '{0, 0, 0, 0, 1000};
        @(negedge clk);
        mem[16'h6000] = 8'hDD; mem[16'h6001] = 8'h36; mem[16'h6002] = 8'h04; mem[16'h6003] = 8'h99;
        exp_q.delete();
        exp_q.push_back('{1'b0, 16'h6000, 8'h00});
        exp_q.push_back('{1'b0, 16'h6001, 8'h00});
        exp_q.push_back('{1'b0, 16'h6002, 8'h00});
        exp_q.push_back('{1'b0, 16'h6003, 8'h00});
        exp_ill = 1'b0;
        xfer_idx = 0;
        waited = 0;
        @(posedge clk); #1;
        start = 1'b1; start_pc = 16'h6000; reg_ix = 16'h0300;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50 && !(bif.bus_req && bif.bus_we); k++) begin
            @(posedge clk); #1;
        end
        chk("reached_write", bif.bus_req && bif.bus_we, 1'b1);
        chk("write_addr_pending", bif.bus_addr, 16'h0304);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_req", bif.bus_req, 1'b0);
        chk("rst_mid_bus", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, 64'd0);
        chk("rst_mid_outs", {busy, done, illegal, retire_insn}, 64'd0);
        chk("rst_mid_retire", {retire_waddr, retire_wdata, retire_pc_next}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        wait_tab = '{0, 0, 0, 0, 0};
        run_insn(16'h7000, 8'hFD, 8'h36, 8'hF0, 8'h3C, 16'h0000, 16'h0100, 1'b0, lat);
        chk("lat_after_reset", lat, 8);
        chk("pin_after_reset_waddr", last_waddr, 16'h00F0);

        // Randomized instructions, ack wait states and stray starts.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] pfx, op;
            logic [15:0] pc;
            int r;
            r = $urandom_range(0, 9);
            pfx = (r < 4) ? 8'hDD : (r < 8) ? 8'hFD : 8'($urandom);
            op  = ($urandom_range(0, 9) < 8) ? 8'h36 : 8'($urandom);
            pc  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
            for (int k = 0; k < 5; k++) wait_tab[k] = $urandom_range(0, 3);
            run_insn(pc, pfx, op, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
                     bit'($urandom_range(0, 1)), lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
